// File: rtl/seq_wide_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 8-bit slice adds a byte per clock,
// least significant byte first, with the inter-byte carry held in a register.

module loop_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module seq_wide_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N    = WIDTH / 8;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;

  logic [IDXW+2:0]  w_base;
  logic [7:0]       w_a_byte;
  logic [7:0]       w_b_byte;
  logic [7:0]       w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_acc_next;

  // Byte lane currently being processed, and the accumulator with it merged in.
  always_comb begin
    w_base     = {r_idx, 3'b000};
    w_a_byte   = r_opa[w_base +: 8];
    w_b_byte   = r_opb[w_base +: 8];
    w_acc_next = r_acc;
    w_acc_next[w_base +: 8] = w_slice_sum;
  end

  loop_adder u_slice (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // Control FSM; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_acc   <= '0;
            r_state <= S_RUN;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + IDX_ONE;
          if (r_idx == LAST_IDX) begin
            sum     <= w_acc_next;
            cout    <= w_slice_cout;
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_wide_adder.sv
// Scoreboard bench for seq_wide_adder (WIDTH=32): expected {cout,sum} and the
// accepting clock number are queued at start and checked when done appears.

module tb_seq_wide_adder;
  localparam int W = 32;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  seq_wide_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (busy || done) check_eq("busy_done_excl", {62'd0, busy, done} & 64'd3 , (busy && done) ? 64'd0 : {62'd0, busy, done});
    if (done) begin
      if (q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check_eq("sum", {32'd0, sum}, {32'd0, e.sum});
        check_eq("cout", {63'd0, cout}, {63'd0, e.cout});
        check_eq("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int acc);
    logic [W:0] full;
    exp_t e;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.sum = full[W-1:0];
    e.cout = full[W];
    e.acc_cyc = acc;
    return e;
  endfunction

  // Issue one operation while the DUT is idle; it is accepted on the next edge.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(posedge clk); #1;
    a = x; b = y; cin = c; start = 1'b1;
    q.push_back(model(x, y, c, cyc + 1));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check_eq("timeout", 64'd1, 64'd0);
      q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    // Reset with the clock stopped.
    #2 rst_n = 1'b0;
    #3;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_sum", {32'd0, sum}, 64'd0);
    check_eq("rst_cout", {63'd0, cout}, 64'd0);
    #3 rst_n = 1'b1;
    clk_en = 1'b1;
    repeat (5) @(posedge clk);

    // Basic op plus busy-width measurement.
    busy_cnt = 0;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_idle();
    check_eq("busy_cycles", 64'(busy_cnt), 64'd4);

    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_idle();
    do_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
    wait_idle();

    // Input isolation: start pulse and operand changes during RUN.
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    start = 1'b1; a = '0; b = '0; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (6) @(posedge clk);

    // Continuous start: an accept every N+2 = 6 clocks.
    @(posedge clk); #1;
    a = 32'h1234_5678; b = 32'h8765_4321; cin = 1'b1; start = 1'b1;
    for (int k = 0; k < 3; k++) q.push_back(model(a, b, cin, cyc + 1 + 6 * k));
    repeat (14) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Reset in the second RUN cycle aborts the operation.
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    q.delete();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_done", {63'd0, done}, 64'd0);
    check_eq("mid_rst_sum", {32'd0, sum}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    do_op(32'h0000_0001, 32'h0000_0001, 1'b0);
    wait_idle();

    // A few random operands.
    for (int k = 0; k < 6; k++) begin
      do_op($urandom, $urandom, 1'($urandom_range(1, 0)));
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
